// File: rtl/alu_pkg.sv
// Shared ALU/issue definitions: ALUOp encodings, RV32I opcodes, branch funct3
// codes, operand selects and the decoded-control record passed from
// alu_decode to alu_issue_ctrl.
`timescale 1ns/1ps
package alu_pkg;

    localparam int unsigned ALU_OPW = 4;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned RD_W    = 5;

    // ALU control encodings; must match the ALU's control input decode
    typedef enum logic [ALU_OPW-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    // RV32I major opcodes
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    // funct7 values accepted on register/shift forms
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2   = 2'd0,
        B_IMM   = 2'd1,
        B_SHAMT = 2'd2
    } b_sel_e;

    // Decoded control for one instruction
    typedef struct packed {
        alu_op_e op;
        a_sel_e  a_sel;
        b_sel_e  b_sel;
        logic    we;
        logic    br;
        logic    br_zero;   // condition from Zero flag, else from result[0]
        logic    br_inv;    // invert the selected condition
        logic    illegal;
    } dec_t;

    // Shared funct3 -> ALUOp map of OP / OP-IMM; alt picks SUB/SRA
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e r;
        r = ALU_ADD;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for the issue stage.
// Ports:
//   instr_i  raw 32-bit instruction word
//   dec_o    ALUOp, operand selects, write enable, branch controls, illegal
`timescale 1ns/1ps
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [OPC_W-1:0] opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             f7b;
    logic [RD_W-1:0]  rd;
    logic             unused_reg_fields;
    dec_t             dec;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign f7b    = instr_i[30];

    // Register specifiers are resolved upstream; operand values arrive as data
    assign unused_reg_fields = ^instr_i[24:15];

    // Opcode/funct decode with legality checks
    always_comb begin
        dec = '0;
        case (opcode)
            OPC_OP: begin
                dec.op = f3_to_op(f3, f7b);
                dec.we = 1'b1;
                if (!(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
                dec.op    = f3_to_op(f3, 1'b0);
                // Shift-immediates carry funct7 in imm[11:5]; only the shamt reaches B
                if (f3 == 3'b001) begin
                    dec.b_sel   = B_SHAMT;
                    dec.illegal = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    dec.b_sel   = B_SHAMT;
                    dec.op      = f7b ? ALU_SRA : ALU_SRL;
                    dec.illegal = !(f7 == F7_BASE || f7 == F7_ALT);
                end
            end
            OPC_LOAD: begin
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel = B_IMM;
            end
            OPC_LUI: begin
                dec.a_sel = A_ZERO;
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel = A_PC;
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
            end
            OPC_BRANCH: begin
                dec.br = 1'b1;
                case (f3)
                    F3_BEQ:  begin dec.op = ALU_SUB;  dec.br_zero = 1'b1; end
                    F3_BNE:  begin dec.op = ALU_SUB;  dec.br_zero = 1'b1; dec.br_inv = 1'b1; end
                    F3_BLT:  begin dec.op = ALU_SLT;  end
                    F3_BGE:  begin dec.op = ALU_SLT;  dec.br_inv = 1'b1; end
                    F3_BLTU: begin dec.op = ALU_SLTU; end
                    F3_BGEU: begin dec.op = ALU_SLTU; dec.br_inv = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase

        // Illegal records carry no side effects and a neutral ALU op
        if (dec.illegal) begin
            dec.op      = ALU_ADD;
            dec.we      = 1'b0;
            dec.br      = 1'b0;
            dec.br_zero = 1'b0;
            dec.br_inv  = 1'b0;
        end
        if (rd == '0) begin
            dec.we = 1'b0;
        end
    end

    assign dec_o = dec;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue stage in front of the combinational ALU. Two pipeline
// registers: D (decoded operands, drives the ALU) and E (captured result and
// writeback/branch record), valid/ready on both sides, 1 record per cycle.
// Ports:
//   clk, rst                        clock, async active-high reset
//   in_valid/in_ready               input record handshake
//   in_instr/in_pc/in_rs1_val/in_rs2_val/in_imm  instruction and operands
//   alu_op/alu_a/alu_b              ALU control and operands from D
//   alu_result/alu_zero             ALU outputs, captured into E
//   out_valid/out_ready             output record handshake
//   out_result/out_rd/out_we/out_br/out_br_taken/out_illegal  E record
`timescale 1ns/1ps
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 4
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_br,
    output logic            out_br_taken,
    output logic            out_illegal
);

    dec_t dec;

    alu_decode u_decode (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

    // D register
    logic            d_valid_q,   d_valid_d;
    logic [OPW-1:0]  d_op_q,      d_op_d;
    logic [XLEN-1:0] d_a_q,       d_a_d;
    logic [XLEN-1:0] d_b_q,       d_b_d;
    logic [4:0]      d_rd_q,      d_rd_d;
    logic            d_we_q,      d_we_d;
    logic            d_br_q,      d_br_d;
    logic            d_br_zero_q, d_br_zero_d;
    logic            d_br_inv_q,  d_br_inv_d;
    logic            d_illegal_q, d_illegal_d;

    // E register
    logic            e_valid_q,   e_valid_d;
    logic [XLEN-1:0] e_result_q,  e_result_d;
    logic [4:0]      e_rd_q,      e_rd_d;
    logic            e_we_q,      e_we_d;
    logic            e_br_q,      e_br_d;
    logic            e_taken_q,   e_taken_d;
    logic            e_illegal_q, e_illegal_d;

    logic            e_free, d_load, e_load;
    logic            br_cond;
    logic [XLEN-1:0] a_mux, b_mux;

    // Handshake: E drains or is empty, D can advance; D accepts when it will be free
    assign e_free   = !e_valid_q || out_ready;
    assign in_ready = !d_valid_q || e_free;
    assign d_load   = in_valid && in_ready;
    assign e_load   = d_valid_q && e_free;

    // Operand selection for the incoming record
    always_comb begin
        case (dec.a_sel)
            A_PC:    a_mux = in_pc;
            A_ZERO:  a_mux = '0;
            default: a_mux = in_rs1_val;
        endcase
        case (dec.b_sel)
            B_IMM:   b_mux = in_imm;
            B_SHAMT: b_mux = XLEN'(in_imm[4:0]);
            default: b_mux = in_rs2_val;
        endcase
    end

    // Branch condition from whichever ALU output the branch kind uses
    assign br_cond = d_br_zero_q ? alu_zero : alu_result[0];

    // Next-state for both pipeline registers
    always_comb begin
        d_valid_d   = d_valid_q;
        d_op_d      = d_op_q;
        d_a_d       = d_a_q;
        d_b_d       = d_b_q;
        d_rd_d      = d_rd_q;
        d_we_d      = d_we_q;
        d_br_d      = d_br_q;
        d_br_zero_d = d_br_zero_q;
        d_br_inv_d  = d_br_inv_q;
        d_illegal_d = d_illegal_q;
        e_valid_d   = e_valid_q;
        e_result_d  = e_result_q;
        e_rd_d      = e_rd_q;
        e_we_d      = e_we_q;
        e_br_d      = e_br_q;
        e_taken_d   = e_taken_q;
        e_illegal_d = e_illegal_q;

        if (d_load) begin
            d_valid_d   = 1'b1;
            d_op_d      = OPW'(dec.op);
            d_a_d       = a_mux;
            d_b_d       = b_mux;
            d_rd_d      = in_instr[11:7];
            d_we_d      = dec.we;
            d_br_d      = dec.br;
            d_br_zero_d = dec.br_zero;
            d_br_inv_d  = dec.br_inv;
            d_illegal_d = dec.illegal;
        end else if (e_load) begin
            d_valid_d   = 1'b0;
        end

        if (e_load) begin
            e_valid_d   = 1'b1;
            e_result_d  = alu_result;
            e_rd_d      = d_rd_q;
            e_we_d      = d_we_q;
            e_br_d      = d_br_q;
            e_taken_d   = d_br_q && (br_cond ^ d_br_inv_q);
            e_illegal_d = d_illegal_q;
        end else if (out_ready) begin
            e_valid_d   = 1'b0;
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q   <= 1'b0;
            d_op_q      <= OPW'(ALU_ADD);
            d_a_q       <= '0;
            d_b_q       <= '0;
            d_rd_q      <= '0;
            d_we_q      <= 1'b0;
            d_br_q      <= 1'b0;
            d_br_zero_q <= 1'b0;
            d_br_inv_q  <= 1'b0;
            d_illegal_q <= 1'b0;
            e_valid_q   <= 1'b0;
            e_result_q  <= '0;
            e_rd_q      <= '0;
            e_we_q      <= 1'b0;
            e_br_q      <= 1'b0;
            e_taken_q   <= 1'b0;
            e_illegal_q <= 1'b0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_op_q      <= d_op_d;
            d_a_q       <= d_a_d;
            d_b_q       <= d_b_d;
            d_rd_q      <= d_rd_d;
            d_we_q      <= d_we_d;
            d_br_q      <= d_br_d;
            d_br_zero_q <= d_br_zero_d;
            d_br_inv_q  <= d_br_inv_d;
            d_illegal_q <= d_illegal_d;
            e_valid_q   <= e_valid_d;
            e_result_q  <= e_result_d;
            e_rd_q      <= e_rd_d;
            e_we_q      <= e_we_d;
            e_br_q      <= e_br_d;
            e_taken_q   <= e_taken_d;
            e_illegal_q <= e_illegal_d;
        end
    end

    assign alu_op       = d_op_q;
    assign alu_a        = d_a_q;
    assign alu_b        = d_b_q;
    assign out_valid    = e_valid_q;
    assign out_result   = e_result_q;
    assign out_rd       = e_rd_q;
    assign out_we       = e_we_q;
    assign out_br       = e_br_q;
    assign out_br_taken = e_taken_q;
    assign out_illegal  = e_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, instruction-level reference
// model with an in-order scoreboard, plus literal expectations.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            alu_zero;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_we, out_br, out_br_taken, out_illegal;

    alu_issue_ctrl #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_br(out_br),
        .out_br_taken(out_br_taken), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // The team ALU, behaviourally
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b0100: alu_result = alu_a << alu_b[4:0];
            4'b0101: alu_result = alu_a ^ alu_b;
            4'b0110: alu_result = alu_a >> alu_b[4:0];
            4'b0111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1000: alu_result = alu_a | alu_b;
            4'b1001: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        taken;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic acc;
    logic hold_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level semantics of one record
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm);
        exp_t       e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] b;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        e   = '0;
        e.rd = instr[11:7];
        case (opc)
            7'b0110011, 7'b0010011: begin
                b = (opc == 7'b0110011) ? rs2 : imm;
                if (opc == 7'b0110011)
                    e.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                else if (f3 == 3'd1)
                    e.illegal = (f7 != 7'h00);
                else if (f3 == 3'd5)
                    e.illegal = !(f7 == 7'h00 || f7 == 7'h20);
                e.we = 1'b1;
                case (f3)
                    3'd0: e.result = (opc == 7'b0110011 && instr[30]) ? rs1 - b : rs1 + b;
                    3'd1: e.result = rs1 << b[4:0];
                    3'd2: e.result = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: e.result = (rs1 < b) ? 32'd1 : 32'd0;
                    3'd4: e.result = rs1 ^ b;
                    3'd5: e.result = instr[30] ? $unsigned($signed(rs1) >>> b[4:0]) : rs1 >> b[4:0];
                    3'd6: e.result = rs1 | b;
                    default: e.result = rs1 & b;
                endcase
            end
            7'b0000011: begin e.result = rs1 + imm; e.we = 1'b1; end
            7'b0100011: begin e.result = rs1 + imm; end
            7'b0110111: begin e.result = imm;       e.we = 1'b1; end
            7'b0010111: begin e.result = pc + imm;  e.we = 1'b1; end
            7'b1100011: begin
                e.br = 1'b1;
                case (f3)
                    3'd0: begin e.result = rs1 - rs2; e.taken = (rs1 == rs2); end
                    3'd1: begin e.result = rs1 - rs2; e.taken = (rs1 != rs2); end
                    3'd4: begin e.result = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
                                e.taken = ($signed(rs1) < $signed(rs2)); end
                    3'd5: begin e.result = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
                                e.taken = ($signed(rs1) >= $signed(rs2)); end
                    3'd6: begin e.result = (rs1 < rs2) ? 32'd1 : 32'd0; e.taken = (rs1 < rs2); end
                    3'd7: begin e.result = (rs1 < rs2) ? 32'd1 : 32'd0; e.taken = (rs1 >= rs2); end
                    default: e.illegal = 1'b1;
                endcase
            end
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) begin
            e.we = 1'b0; e.br = 1'b0; e.taken = 1'b0;
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, 5'd1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3);
        return {7'b0, 5'd2, 5'd1, f3, 5'b0, 7'b1100011};
    endfunction

    // One cycle: compare/track at the falling edge, then step past the rising edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
            if (hold_prev) chk("valid_held", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got out_valid=1 expected no record at %0t", $time);
                end else begin
                    e = sb[0];
                    if (!e.illegal) chk("out_result", out_result, e.result);
                    chk("out_rd",       32'(out_rd),       32'(e.rd));
                    chk("out_we",       32'(out_we),       32'(e.we));
                    chk("out_br",       32'(out_br),       32'(e.br));
                    chk("out_br_taken", 32'(out_br_taken), 32'(e.taken));
                    chk("out_illegal",  32'(out_illegal),  32'(e.illegal));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            hold_prev = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                sb.push_back(model(in_instr, in_pc, in_rs1_val, in_rs2_val, in_imm));
                acc = 1'b1;
            end
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm);
        int n;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_pc      = pc;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_imm     = imm;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            step();
            n++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; hold_prev = 1'b0;
        in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_alu_op",     32'(alu_op),     32'd0);
        chk("rst_alu_a",      alu_a,           32'd0);
        chk("rst_out_result", out_result,      32'd0);
        chk("rst_out_illegal",32'(out_illegal),32'd0);
        rst = 1'b0;
        step();

        // ADD x3,x1,x2: D after accept, E one edge later
        send(enc_r(7'h00, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7, 32'h0);
        chk("add_alu_op",    32'(alu_op),    32'd0);
        chk("add_alu_a",     alu_a,          32'd5);
        chk("add_alu_b",     alu_b,          32'd7);
        chk("add_not_yet",   32'(out_valid), 32'd0);
        step();
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_result",    out_result,     32'd12);
        chk("add_rd",        32'(out_rd),    32'd3);
        chk("add_we",        32'(out_we),    32'd1);

        send(enc_r(7'h20, 3'd0, 5'd5), 32'h0, 32'd3, 32'd5, 32'h0);
        step();
        chk("sub_result", out_result, 32'hFFFF_FFFE);

        send(enc_i(12'h404, 3'd5, 5'd4, 7'b0010011), 32'h0, 32'h8000_0000, 32'h0, 32'h404);
        chk("srai_alu_op", 32'(alu_op), 32'd7);
        step();
        chk("srai_result", out_result, 32'hF800_0000);

        send(enc_b(3'd0), 32'h0, 32'd9, 32'd9, 32'h0);
        step();
        chk("beq_br",    32'(out_br),       32'd1);
        chk("beq_taken", 32'(out_br_taken), 32'd1);
        chk("beq_we",    32'(out_we),       32'd0);

        send(enc_b(3'd6), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        chk("bltu_alu_op", 32'(alu_op), 32'd9);
        step();
        chk("bltu_taken", 32'(out_br_taken), 32'd0);

        send(enc_b(3'd4), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        chk("blt_alu_op", 32'(alu_op), 32'd3);
        step();
        chk("blt_taken", 32'(out_br_taken), 32'd1);

        send(32'h0000_007F, 32'h0, 32'd1, 32'd2, 32'h0);
        step();
        chk("badopc_illegal", 32'(out_illegal), 32'd1);
        chk("badopc_we",      32'(out_we),      32'd0);

        send(enc_r(7'b0000001, 3'd0, 5'd5), 32'h0, 32'd1, 32'd2, 32'h0);
        step();
        chk("mul_illegal", 32'(out_illegal), 32'd1);
        chk("mul_we",      32'(out_we),      32'd0);

        send({12'd9, 5'd0, 3'd0, 5'd0, 7'b0010011}, 32'h0, 32'd0, 32'd0, 32'd9);
        step();
        chk("addi_x0_we", 32'(out_we), 32'd0);
        drain(3);

        // Back-to-back mix, scoreboard only
        send(enc_r(7'h00, 3'd2, 5'd5), 32'h0, 32'hFFFF_FFF0, 32'd3, 32'h0);
        send(enc_r(7'h00, 3'd3, 5'd5), 32'h0, 32'hFFFF_FFF0, 32'd3, 32'h0);
        send(enc_r(7'h00, 3'd4, 5'd5), 32'h0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h0);
        send(enc_r(7'h00, 3'd5, 5'd6), 32'h0, 32'h8000_0000, 32'd35, 32'h0);
        send(enc_r(7'h20, 3'd5, 5'd6), 32'h0, 32'h8000_0000, 32'd35, 32'h0);
        send(enc_r(7'h00, 3'd1, 5'd6), 32'h0, 32'd1, 32'd31, 32'h0);
        send(enc_r(7'h00, 3'd6, 5'd7), 32'h0, 32'h00F0_0000, 32'h0000_0F0F, 32'h0);
        send(enc_r(7'h00, 3'd7, 5'd7), 32'h0, 32'h00FF_FF00, 32'h0F0F_0F0F, 32'h0);
        send(enc_r(7'h20, 3'd2, 5'd7), 32'h0, 32'd1, 32'd2, 32'h0);
        send({20'h12345, 5'd8, 7'b0110111}, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h1234_5000);
        send({20'h00001, 5'd8, 7'b0010111}, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0000_1000);
        send(enc_i(12'hFFC, 3'd2, 5'd9, 7'b0000011), 32'h0, 32'h1000, 32'h0, 32'hFFFF_FFFC);
        send({7'b0, 5'd2, 5'd1, 3'd2, 5'd4, 7'b0100011}, 32'h0, 32'h2000, 32'd5, 32'd8);
        send(enc_b(3'd1), 32'h0, 32'd4, 32'd4, 32'h0);
        send(enc_b(3'd5), 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0);
        send(enc_b(3'd7), 32'h0, 32'd0, 32'd1, 32'h0);
        send(enc_b(3'd2), 32'h0, 32'd0, 32'd1, 32'h0);
        send(enc_i({7'h20, 5'd3}, 3'd1, 5'd5, 7'b0010011), 32'h0, 32'd1, 32'h0, 32'h0000_0403);
        send(enc_i(12'h400, 3'd0, 5'd5, 7'b0010011), 32'h0, 32'd1, 32'h0, 32'h0000_0400);
        send(enc_i(12'h008, 3'd5, 5'd5, 7'b0010011), 32'h0, 32'hF000_0000, 32'h0, 32'd8);
        send(enc_i(12'hFFF, 3'd3, 5'd5, 7'b0010011), 32'h0, 32'd5, 32'h0, 32'hFFFF_FFFF);
        drain(4);

        // Stall: fill D and E with out_ready low, third record must wait
        out_ready = 1'b0;
        send(enc_r(7'h00, 3'd0, 5'd10), 32'h0, 32'd1, 32'd2, 32'h0);
        send(enc_r(7'h00, 3'd4, 5'd11), 32'h0, 32'h0000_00FF, 32'h0000_0F0F, 32'h0);
        in_valid = 1'b1; in_instr = enc_r(7'h00, 3'd6, 5'd12);
        in_rs1_val = 32'h1000_0000; in_rs2_val = 32'h0000_0001; in_imm = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 32'(in_ready),  32'd0);
            chk("stall_valid",    32'(out_valid), 32'd1);
            chk("stall_result",   out_result,     32'd3);
        end
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            acc = 1'b0;
            while (!acc && n < 20) begin
                step();
                n++;
            end
            chk("stall_release_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        drain(4);
        chk("stall_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset with a record on the output
        send(enc_r(7'h00, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7, 32'h0);
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid",  32'(out_valid),    32'd0);
        chk("arst_out_result", out_result,        32'd0);
        chk("arst_out_rd",     32'(out_rd),       32'd0);
        chk("arst_out_we",     32'(out_we),       32'd0);
        chk("arst_alu_op",     32'(alu_op),       32'd0);
        chk("arst_alu_a",      alu_a,             32'd0);
        chk("arst_alu_b",      alu_b,             32'd0);
        chk("arst_br_taken",   32'(out_br_taken), 32'd0);
        sb.delete();
        hold_prev = 1'b0;
        step();
        step();
        rst = 1'b0;
        send(enc_r(7'h00, 3'd0, 5'd7), 32'h0, 32'd100, 32'd23, 32'h0);
        chk("post_rst_alu_a",  alu_a,            32'd100);
        chk("post_rst_early",  32'(out_valid),   32'd0);
        step();
        chk("post_rst_valid",  32'(out_valid),   32'd1);
        chk("post_rst_result", out_result,       32'd123);
        chk("post_rst_rd",     32'(out_rd),      32'd7);
        drain(3);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
